// File: rtl/l2_snoop_agent.sv
// L2-side agent for the L1 data cache: queues L1 bus messages and completes them after a modelled
// L2 latency, and independently drives invalidate / data-request snoops into the L1.
module l2_snoop_agent #(
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = 6,
    parameter int L2_LAT      = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l1_msg_valid,
    output logic              l1_msg_ready,
    input  logic [1:0]        l1_msg_type,
    input  logic [ADDR_W-1:0] l1_msg_addr,
    output logic              l1_rsp_valid,
    input  logic              l1_rsp_ready,
    output logic [1:0]        l1_rsp_type,
    output logic [ADDR_W-1:0] l1_rsp_addr,
    input  logic              snp_req_valid,
    output logic              snp_req_ready,
    input  logic              snp_req_cmd,
    input  logic [ADDR_W-1:0] snp_req_addr,
    output logic              l1_cmd_valid,
    output logic [3:0]        l1_cmd,
    output logic [ADDR_W-1:0] l1_cmd_addr,
    input  logic              l1_cmd_ack,
    input  logic              l1_cmd_hitm,
    output logic              snp_done,
    output logic              snp_hitm,
    output logic [CNT_W-1:0]  cnt_read,
    output logic [CNT_W-1:0]  cnt_write,
    output logic [CNT_W-1:0]  cnt_rfo,
    output logic [CNT_W-1:0]  cnt_evict,
    output logic [CNT_W-1:0]  cnt_snoop
);

    // Handshake rule on every port: a transfer happens on the rising edge where valid and ready are
    // both high; valid, once raised, is held with stable payload until that edge (or the ack edge).

    localparam int PTR_W  = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int QCNT_W = PTR_W + 1;
    localparam int TMR_W  = (L2_LAT < 2) ? 1 : $clog2(L2_LAT + 1);

    localparam logic [1:0] MSG_READ  = 2'd0;
    localparam logic [1:0] MSG_WRITE = 2'd1;
    localparam logic [1:0] MSG_RFO   = 2'd2;
    localparam logic [1:0] MSG_EVICT = 2'd3;

    localparam logic [3:0] CMD_L2_INVAL   = 4'd3;
    localparam logic [3:0] CMD_L2_DATA_RQ = 4'd4;

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFFSET_BITS) - 64'd1);

    typedef enum logic [1:0] {SVC_IDLE, SVC_BUSY, SVC_RESP} svc_state_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_WB} snp_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------ message queue
    logic [1:0]        q_type [FIFO_DEPTH];
    logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [QCNT_W-1:0] q_count;
    logic              q_full, q_empty, push, pop;

    svc_state_t svc_state, svc_next;

    assign q_full       = (q_count == QCNT_W'(FIFO_DEPTH));
    assign q_empty      = (q_count == '0);
    assign l1_msg_ready = !q_full;
    assign push         = l1_msg_valid && !q_full;
    assign pop          = (svc_state == SVC_IDLE) && !q_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      q_count <= q_count + QCNT_W'(1);
            else if (!push && pop) q_count <= q_count - QCNT_W'(1);
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_type[wr_ptr] <= l1_msg_type;
            q_addr[wr_ptr] <= l1_msg_addr & ~OFF_MASK;
        end
    end

    // ------------------------------------------------------------------ service FSM
    logic [TMR_W-1:0]  timer;
    logic [1:0]        rsp_type_q;
    logic [ADDR_W-1:0] rsp_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            svc_state  <= SVC_IDLE;
            timer      <= '0;
            rsp_type_q <= '0;
            rsp_addr_q <= '0;
        end else begin
            svc_state <= svc_next;
            if (pop) begin
                timer      <= (q_type[rd_ptr] == MSG_READ || q_type[rd_ptr] == MSG_RFO)
                              ? TMR_W'(L2_LAT) : TMR_W'(1);
                rsp_type_q <= q_type[rd_ptr];
                rsp_addr_q <= q_addr[rd_ptr];
            end else if (svc_state == SVC_BUSY && timer != TMR_W'(1)) begin
                timer <= timer - TMR_W'(1);
            end
        end
    end

    always_comb begin
        svc_next     = svc_state;
        l1_rsp_valid = 1'b0;
        case (svc_state)
            SVC_IDLE: if (!q_empty) svc_next = SVC_BUSY;
            SVC_BUSY: if (timer == TMR_W'(1)) svc_next = SVC_RESP;
            SVC_RESP: begin
                l1_rsp_valid = 1'b1;
                if (l1_rsp_ready) svc_next = SVC_IDLE;
            end
            default:  svc_next = SVC_IDLE;
        endcase
    end

    assign l1_rsp_type = rsp_type_q;
    assign l1_rsp_addr = rsp_addr_q;

    // ------------------------------------------------------------------ snoop FSM
    snp_state_t        snp_state, snp_next;
    logic              snp_cmd_q;
    logic [ADDR_W-1:0] snp_addr_q;
    logic              wb_match;

    // Only a WRITE accepted while already waiting counts as the writeback; one landing on the
    // ack cycle is queued as an ordinary write.
    assign wb_match = push && (l1_msg_type == MSG_WRITE) &&
                      ((l1_msg_addr & ~OFF_MASK) == snp_addr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snp_state  <= S_IDLE;
            snp_cmd_q  <= 1'b0;
            snp_addr_q <= '0;
        end else begin
            snp_state <= snp_next;
            if (snp_state == S_IDLE && snp_req_valid) begin
                snp_cmd_q  <= snp_req_cmd;
                snp_addr_q <= snp_req_addr & ~OFF_MASK;
            end
        end
    end

    always_comb begin
        snp_next      = snp_state;
        snp_req_ready = 1'b0;
        l1_cmd_valid  = 1'b0;
        l1_cmd        = 4'd0;
        snp_done      = 1'b0;
        snp_hitm      = 1'b0;
        case (snp_state)
            S_IDLE: begin
                snp_req_ready = 1'b1;
                if (snp_req_valid) snp_next = S_ISSUE;
            end
            S_ISSUE: begin
                l1_cmd_valid = 1'b1;
                l1_cmd       = snp_cmd_q ? CMD_L2_DATA_RQ : CMD_L2_INVAL;
                if (l1_cmd_ack) begin
                    if (l1_cmd_hitm) begin
                        snp_next = S_WAIT_WB;
                    end else begin
                        snp_done = 1'b1;
                        snp_next = S_IDLE;
                    end
                end
            end
            S_WAIT_WB: begin
                if (wb_match) begin
                    snp_done = 1'b1;
                    snp_hitm = 1'b1;
                    snp_next = S_IDLE;
                end
            end
            default: snp_next = S_IDLE;
        endcase
    end

    assign l1_cmd_addr = snp_addr_q;

    // ------------------------------------------------------------------ statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_read  <= '0;
            cnt_write <= '0;
            cnt_rfo   <= '0;
            cnt_evict <= '0;
            cnt_snoop <= '0;
        end else begin
            if (push && l1_msg_type == MSG_READ)  cnt_read  <= sat_inc(cnt_read);
            if (push && l1_msg_type == MSG_WRITE) cnt_write <= sat_inc(cnt_write);
            if (push && l1_msg_type == MSG_RFO)   cnt_rfo   <= sat_inc(cnt_rfo);
            if (push && l1_msg_type == MSG_EVICT) cnt_evict <= sat_inc(cnt_evict);
            if (snp_done)                         cnt_snoop <= sat_inc(cnt_snoop);
        end
    end

endmodule
